// File: rtl/fnorm32.sv
// FP32 add/sub back end: left-normalises the aligned mantissa sum one bit per clock, rounds RNE and packs.
// Optional flush-to-zero of subnormal results when FNORM_FTZ_EN is defined.
module fnorm32 #(
  parameter int MAN_W = 27,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_cout,
  input  logic [MAN_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      res
);

  typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, OUT} state_t;

  state_t      state;
  logic [26:0] m;
  logic [9:0]  e;
  logic        s;
  logic [23:0] f_r;
  logic [9:0]  e_r;

  logic [9:0]  exp_in;
  logic        up;
  logic [24:0] f25;
  logic [23:0] f_rnd;
  logic [9:0]  e_rnd;
  logic [31:0] packed_res;

  assign in_ready = (state == IDLE) && !rst;

  // Exponent is kept 10 bits wide so the carry and rounding increments past 255 stay visible.
  always_comb begin
    exp_in = (in_exp == '0) ? 10'd1 : {2'b00, in_exp};
    up     = m[2] & (m[1] | m[0] | m[3]);
    f25    = {1'b0, m[26:3]} + {24'b0, up};
    if (f25[24]) begin
      f_rnd = f25[24:1];
      e_rnd = e + 10'd1;
    end else begin
      f_rnd = f25[23:0];
      e_rnd = e;
    end
  end

  // A cleared hidden bit after rounding means the result stays subnormal, so the exponent field is 0.
  always_comb begin
    if (e_r >= 10'd255)
      packed_res = {s, 8'hFF, 23'h0};
    else
      packed_res = {s, (f_r[23] ? e_r[7:0] : 8'h00), f_r[22:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      res       <= 32'h0;
      m         <= '0;
      e         <= '0;
      s         <= 1'b0;
      f_r       <= '0;
      e_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s <= in_sign;
            if (in_exp == 8'hFF) begin
              res       <= {in_sign, 8'hFF, in_sum[25:3]};
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              if (in_cout) begin
                m <= {1'b1, in_sum[26:2], in_sum[1] | in_sum[0]};
                e <= exp_in + 10'd1;
              end else begin
                m <= in_sum;
                e <= exp_in;
              end
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (m == '0) begin
            res       <= 32'h0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (e == 10'd255) begin
            state <= ROUND;
          end else if (!m[26] && e > 10'd1) begin
            m <= {m[25:0], 1'b0};
            e <= e - 10'd1;
`ifdef FNORM_FTZ_EN
          end else if (!m[26]) begin
            res       <= {s, 31'h0};
            out_valid <= 1'b1;
            state     <= OUT;
`endif
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          f_r   <= f_rnd;
          e_r   <= e_rnd;
          state <= PACK;
        end
        PACK: begin
          res       <= packed_res;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fnorm32.sv
// Self-checking bench for fnorm32: directed corner cases plus randomized operands against an arithmetic model.
module tb_fnorm32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic        in_cout;
  logic [26:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;

  int tests_run;
  int tests_failed;

  fnorm32 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sign  (in_sign),
    .in_exp   (in_exp),
    .in_cout  (in_cout),
    .in_sum   (in_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Value-level model: integer mantissa, leading-zero normalisation loop, RNE via remainder comparison.
  function automatic void refModel(input logic sg, input logic [7:0] ex, input logic cy,
                                   input logic [26:0] sm, output logic [31:0] r, output int lat);
    longint mm;
    int ee, q, rem;
    if (ex == 8'hFF) begin
      r = {sg, 8'hFF, sm[25:3]};
      lat = 0;
      return;
    end
    ee = (ex == 0) ? 1 : int'(ex);
    mm = longint'(sm);
    if (cy) begin
      mm = ((mm + (longint'(1) << 27)) >> 1) | longint'(sm[0]);
      ee++;
    end
    lat = 1;
    if (mm == 0) begin
      r = 32'h0;
      return;
    end
    while (mm < (longint'(1) << 26) && ee > 1 && ee != 255) begin
      mm = mm * 2;
      ee--;
      lat++;
    end
`ifdef FNORM_FTZ_EN
    if (mm < (longint'(1) << 26)) begin
      r = {sg, 31'h0};
      return;
    end
`endif
    lat += 2;
    q = int'(mm / 8);
    rem = int'(mm % 8);
    if (rem > 4 || (rem == 4 && (q % 2) == 1)) q++;
    if (q >= (1 << 24)) begin
      q = q / 2;
      ee++;
    end
    if (ee >= 255) r = {sg, 8'hFF, 23'h0};
    else r = {sg, ((q >= (1 << 23)) ? 8'(ee) : 8'h00), 23'(q)};
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One full transaction, entered and left on a falling edge; stall holds out_ready low that many cycles.
  task automatic applyStimulus(input string tag, input logic sg, input logic [7:0] ex, input logic cy,
                               input logic [26:0] sm, input int stall);
    logic [31:0] want;
    int want_lat, lat, w;
    refModel(sg, ex, cy, sm, want, want_lat);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checkOutput({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
      doReset();
      return;
    end
    in_valid = 1'b1;
    in_sign  = sg;
    in_exp   = ex;
    in_cout  = cy;
    in_sum   = sm;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sum   = 27'($urandom);
    in_exp   = 8'($urandom);
    in_cout  = 1'($urandom);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 60) begin
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      checkOutput({tag, "_out_valid_timeout"}, 32'(out_valid), 32'd1);
      doReset();
      return;
    end
    checkOutput({tag, "_res"}, res, want);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(want_lat));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput({tag, "_stall_res"}, res, want);
      checkOutput({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({tag, "_stall_out_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_done_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [31:0] want;
    int want_lat, lat;
    logic [7:0]  rex;
    logic [26:0] rsum;
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'h0;
    in_cout   = 1'b0;
    in_sum    = 27'h0;
    out_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_res", res, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

    applyStimulus("one",      1'b0, 8'd127, 1'b0, 27'h4000000, 0);
    applyStimulus("two",      1'b0, 8'd127, 1'b1, 27'h0000000, 0);
    applyStimulus("shift23",  1'b0, 8'd127, 1'b0, 27'h0000008, 0);
    applyStimulus("rne_even", 1'b0, 8'd127, 1'b0, 27'h4000004, 0);
    applyStimulus("rne_up",   1'b0, 8'd127, 1'b0, 27'h400000C, 0);
    applyStimulus("ovf_inf",  1'b1, 8'd254, 1'b1, 27'h0000000, 0);
    applyStimulus("subnorm",  1'b0, 8'd1,   1'b0, 27'h2000000, 0);
    applyStimulus("zero",     1'b1, 8'd100, 1'b0, 27'h0000000, 0);
    applyStimulus("special",  1'b1, 8'd255, 1'b0, 27'h1234568, 0);
    applyStimulus("sub_rnd",  1'b0, 8'd0,   1'b0, 27'h3FFFFFC, 0);
    applyStimulus("backpres", 1'b0, 8'd130, 1'b0, 27'h0800000, 5);

    // Output handshake and a new request in the same OUT cycle: only the output side completes.
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_cout = 1'b0; in_sum = 27'h4000000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 60) begin
      lat++;
      @(negedge clk);
    end
    checkOutput("overlap_first_res", res, 32'h3F800000);
    refModel(1'b1, 8'd128, 1'b0, 27'h6000000, want, want_lat);
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'd128; in_sum = 27'h6000000;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("overlap_out_valid", 32'(out_valid), 32'd0);
    checkOutput("overlap_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 60) begin
      lat++;
      @(negedge clk);
    end
    checkOutput("overlap_second_res", res, want);
    checkOutput("overlap_second_lat", 32'(lat), 32'(want_lat));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);

    // Abort a long normalisation with reset.
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_cout = 1'b0; in_sum = 27'h0000008;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_res", res, 32'h0);
    checkOutput("abort_in_ready_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (30) @(negedge clk);
    checkOutput("abort_no_late_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: rex = 8'($urandom_range(0, 4));
        1: rex = 8'($urandom_range(250, 255));
        default: rex = 8'($urandom_range(0, 255));
      endcase
      rsum = 27'($urandom) >> $urandom_range(0, 26);
      applyStimulus($sformatf("rand%0d", i), 1'($urandom), rex, 1'($urandom), rsum, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
